scarf_trigger_engine: RTL and testbench
=======================================

Name: scarf_trigger_engine

Overview:
- Downstream consumer of the SCARF trigger register map. Monitors one asynchronous input and raises a trigger when a configured edge, pulse-width or idle condition has occurred a configured number of times.
- Converts the cfg_* fields into a one-cycle trigger_pulse and a sticky triggered flag for capture and sample logic.

Parameters:
- SYNC_STAGES, 2, number of synchronizer flops on sig_in (minimum 2).

Ports:
- clk  input  1  system clock
- rst_sync  input  1  synchronous reset, active-high
- sig_in  input  1  asynchronous monitored signal
- cfg_enable  input  1  arm the engine; deassert to disarm and clear
- cfg_positive  input  1  1 = active-high pulses / rising leading edge; 0 = active-low / falling
- cfg_type  input  3  0 EDGE, 1 WIDTH_GT, 2 WIDTH_LT, 3 WIDTH_IN, 4 IDLE, 5-7 reserved
- cfg_stage1_count  input  4  qualifying events required to trigger (0 treated as 1)
- cfg_time_base  input  3  tick period = 4^cfg_time_base clocks (1 to 16384)
- cfg_count1  input  8  width/idle threshold in ticks
- cfg_count2  input  8  upper width bound for WIDTH_IN
- cfg_longer_no_edge  input  1  WIDTH_GT fires at threshold crossing, not at trailing edge
- armed  output  1  engine in ARMED or MEASURE
- triggered  output  1  sticky; set with trigger_pulse
- trigger_pulse  output  1  one-clock trigger strobe
- event_count  output  4  qualifying events seen since arming

Behaviour:
- Reset (rst_sync=1 at posedge): all outputs 0, state IDLE, synchronizer, prescaler and counters cleared. Reset mid-operation aborts immediately.
- Synchronizer: sig_s is the last synchronizer flop and sig_d is sig_s delayed one clock. Leading edge = sig_s active and sig_d inactive, where "active" is the level selected by cfg_positive. Trailing edge is the reverse.
- Config snapshot: all cfg_* except cfg_enable are registered on the IDLE->ARMED transition. Changes while enabled are ignored.
- Prescaler: 14-bit counter; tick asserts when it equals 4^tb-1. It is cleared on arming and on any edge, so a tick occurs on the edge cycle itself.
- Width counter: 8-bit, saturating at 255. Cleared to 0 on the leading edge, then increments on each tick while sig_s is active, including the leading-edge cycle. At tb=0 the width equals pulse length in clocks.
- FSM states:
  - IDLE: armed=0. Moves to ARMED when cfg_enable=1.
  - ARMED: waits for a leading edge, then MEASURE. For type 4, the idle timer runs here.
  - MEASURE: counts width. On the trailing edge it evaluates and returns to ARMED.
  - TRIGGERED: holds; no further events.
  - Any state goes to IDLE when cfg_enable=0. Leaving to IDLE clears triggered and event_count.
- Events by type:
  - EDGE: event on each leading edge.
  - WIDTH_GT: event at the trailing edge if width > count1. If longer_no_edge=1, the event fires on the cycle width becomes count1+1 while still active (once per pulse); saturation at 255 counts as greater.
  - WIDTH_LT: event at the trailing edge if width < count1.
  - WIDTH_IN: event if count1 <= width <= count2. Never fires when count1 > count2.
  - IDLE: 8-bit timer counts ticks, restarts on any edge, and gives an event when it reaches count1 (count1=0 means first tick after arming). Timer restarts after each event.
  - Reserved types: no events; engine stays armed.
- Trigger: each event increments event_count, saturating at 15. When event_count+1 reaches the effective stage1 count, the engine:
  - registers trigger_pulse=1 for exactly one clock;
  - sets triggered=1;
  - enters TRIGGERED.
- Latency: for EDGE with stage1=1, trigger_pulse is high SYNC_STAGES+1 clocks after the clock edge that first samples the new sig_in level.
- Simultaneous events:
  - cfg_enable falling in the same cycle as an event: disarm wins, no pulse.
  - Edge in the same cycle as a tick: the prescaler clear wins.
- sig_in already active at arming: no leading edge is inferred; the engine waits for a fresh leading edge.

Test Plan:
- EDGE: type0, pos=1, stage1=1, enable, then sig_in 0->1 -> trigger_pulse high exactly 3 clocks later for 1 clock; triggered stays 1; further edges give no pulse.
- WIDTH_GT: type1, tb=0, count1=10 -> 10-clock pulse gives no event; 11-clock pulse triggers on its trailing edge. With longer_no_edge=1, a 50-clock pulse triggers on clock 11 of the pulse.
- WIDTH_IN with prescale: type3, tb=1 (4 clocks/tick), count1=3, count2=5 -> pulses of 8, 16 and 24 clocks give event_count 0, 1, 1. count1=6, count2=2 never triggers.
- Stage count: type0, pos=0, stage1=3 -> three falling edges give event_count 1, 2 and trigger on the third. stage1=0 triggers on the first.
- IDLE: type4, tb=0, count1=20 -> edges every 15 clocks give no trigger; a 20-clock gap after the last edge triggers.
- Control: deassert cfg_enable mid-MEASURE -> armed=0, event_count=0, no pulse. Change count1 while armed -> ignored. rst_sync pulse -> all outputs 0 next clock.

Source files
------------

// File: rtl/scarf_trigger_engine.sv
// -----------------------------------------------------------------------------
// scarf_trigger_engine
//
// Watches one asynchronous input and raises a trigger once a configured
// qualifying condition (edge, pulse width or idle time) has been seen a
// configured number of times. The engine produces a one-clock trigger_pulse
// and a sticky triggered flag for the capture and sample logic.
//
// Ports
//   clk                 system clock
//   rst_sync            synchronous reset, active-high
//   sig_in              asynchronous monitored signal
//   cfg_enable          arm the engine; low disarms and clears
//   cfg_positive        1 = active-high / rising leading edge, 0 = active-low
//   cfg_type[2:0]       0 EDGE, 1 WIDTH_GT, 2 WIDTH_LT, 3 WIDTH_IN, 4 IDLE
//   cfg_stage1_count    qualifying events needed to trigger (0 behaves as 1)
//   cfg_time_base[2:0]  tick period = 4^cfg_time_base clocks
//   cfg_count1[7:0]     width / idle threshold in ticks
//   cfg_count2[7:0]     upper width bound for WIDTH_IN
//   cfg_longer_no_edge  WIDTH_GT fires at threshold crossing instead of at
//                       the trailing edge
//   armed               engine is in ARMED or MEASURE
//   triggered           sticky, set together with trigger_pulse
//   trigger_pulse       one-clock trigger strobe
//   event_count[3:0]    qualifying events since arming (saturates at 15)
// -----------------------------------------------------------------------------
module scarf_trigger_engine #(
   parameter int SYNC_STAGES = 2   // must be at least 2
) (
   input  logic       clk,
   input  logic       rst_sync,
   input  logic       sig_in,
   input  logic       cfg_enable,
   input  logic       cfg_positive,
   input  logic [2:0] cfg_type,
   input  logic [3:0] cfg_stage1_count,
   input  logic [2:0] cfg_time_base,
   input  logic [7:0] cfg_count1,
   input  logic [7:0] cfg_count2,
   input  logic       cfg_longer_no_edge,
   output logic       armed,
   output logic       triggered,
   output logic       trigger_pulse,
   output logic [3:0] event_count
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_ARMED   = 2'd1,
      S_MEASURE = 2'd2,
      S_TRIG    = 2'd3
   } state_t;

   localparam logic [2:0] T_EDGE = 3'd0;
   localparam logic [2:0] T_WGT  = 3'd1;
   localparam logic [2:0] T_WLT  = 3'd2;
   localparam logic [2:0] T_WIN  = 3'd3;
   localparam logic [2:0] T_IDLE = 3'd4;

   state_t                   state_q, state_d;
   logic [SYNC_STAGES-1:0]   sync_q, sync_d;
   logic                     sig_dly_q, sig_dly_d;     // sig_s delayed one clock
   logic                     pos_q, pos_d;
   logic [2:0]               type_q, type_d;
   logic [3:0]               stage_q, stage_d;
   logic [2:0]               tb_q, tb_d;
   logic [7:0]               c1_q, c1_d;
   logic [7:0]               c2_q, c2_d;
   logic                     lne_q, lne_d;
   logic [13:0]              presc_q, presc_d;
   logic [7:0]               width_q, width_d;
   logic [7:0]               idle_q, idle_d;
   logic                     evt_q, evt_d;
   logic [3:0]               event_count_q, event_count_d;
   logic                     triggered_q, triggered_d;
   logic                     trigger_pulse_q, trigger_pulse_d;

   logic        sig_s, act_s, act_d, lead, trail, any_edge;
   logic        arm_now, run, tick, width_step, idle_hit, evt_c, take_evt, fire;
   logic [13:0] tick_max;
   logic [7:0]  gt_cap;
   logic [3:0]  stage_eff;

   assign sig_s    = sync_q[SYNC_STAGES-1];
   // Polarity comes from the snapshot so a live cfg_positive change is ignored.
   assign act_s    = pos_q ? sig_s : ~sig_s;
   assign act_d    = pos_q ? sig_dly_q : ~sig_dly_q;
   assign lead     = act_s & ~act_d;
   assign trail    = ~act_s & act_d;
   assign any_edge = sig_s ^ sig_dly_q;

   assign arm_now  = (state_q == S_IDLE) & cfg_enable;
   assign run      = cfg_enable & ((state_q == S_ARMED) | (state_q == S_MEASURE));

   // 4^tb - 1; tb=7 gives 16383, which needs the wider intermediate.
   assign tick_max = 14'((15'd1 << {tb_q, 1'b0}) - 15'd1);
   // Any edge forces a tick so width/idle counting starts in phase with it.
   assign tick     = any_edge | (presc_q == tick_max);

   assign width_step = act_s & tick & (width_q != 8'hFF);
   // A saturated counter (255) counts as beyond a threshold of 255.
   assign gt_cap     = (c1_q == 8'hFF) ? 8'hFF : c1_q + 8'd1;
   assign idle_hit   = tick & ~any_edge & (idle_q == c1_q);
   assign stage_eff  = (stage_q == 4'd0) ? 4'd1 : stage_q;

   // Events are registered once (evt_q) before being counted, which sets the
   // sig_in-to-trigger_pulse latency at SYNC_STAGES+1 clocks.
   assign take_evt = run & evt_q;
   assign fire     = take_evt & (({1'b0, event_count_q} + 5'd1) >= {1'b0, stage_eff});

   always_comb begin : datapath
      sync_d    = {sync_q[SYNC_STAGES-2:0], sig_in};
      sig_dly_d = sig_s;

      pos_d   = pos_q;
      type_d  = type_q;
      stage_d = stage_q;
      tb_d    = tb_q;
      c1_d    = c1_q;
      c2_d    = c2_q;
      lne_d   = lne_q;
      if (arm_now) begin
         pos_d   = cfg_positive;
         type_d  = cfg_type;
         stage_d = cfg_stage1_count;
         tb_d    = cfg_time_base;
         c1_d    = cfg_count1;
         c2_d    = cfg_count2;
         lne_d   = cfg_longer_no_edge;
      end

      if ((state_q == S_IDLE) || tick)
         presc_d = 14'd0;
      else
         presc_d = presc_q + 14'd1;

      // The leading-edge cycle is always a tick, so the width restarts at 1.
      if (arm_now)
         width_d = 8'd0;
      else if (lead)
         width_d = 8'd1;
      else if (width_step)
         width_d = width_q + 8'd1;
      else
         width_d = width_q;

      // Idle timer spans ARMED and MEASURE: it measures time since any edge.
      if ((state_q == S_IDLE) || any_edge || idle_hit)
         idle_d = 8'd0;
      else if (tick)
         idle_d = idle_q + 8'd1;
      else
         idle_d = idle_q;

      evt_c = 1'b0;
      case (type_q)
         T_EDGE: evt_c = (state_q == S_ARMED) & lead;
         T_WGT:
            if (lne_q)
               evt_c = ((state_q == S_ARMED) & lead & (gt_cap == 8'd1)) |
                       ((state_q == S_MEASURE) & width_step & (width_d == gt_cap));
            else
               evt_c = (state_q == S_MEASURE) & trail & (width_q > c1_q);
         T_WLT:  evt_c = (state_q == S_MEASURE) & trail & (width_q < c1_q);
         T_WIN:  evt_c = (state_q == S_MEASURE) & trail &
                         (width_q >= c1_q) & (width_q <= c2_q);
         T_IDLE: evt_c = idle_hit;
         default: evt_c = 1'b0;
      endcase
      evt_d = run & evt_c;

      if (!cfg_enable || (state_q == S_IDLE))
         event_count_d = 4'd0;
      else if (take_evt && (event_count_q != 4'hF))
         event_count_d = event_count_q + 4'd1;
      else
         event_count_d = event_count_q;

      trigger_pulse_d = fire;
      triggered_d     = cfg_enable & (triggered_q | fire);
   end

   always_comb begin : fsm_next
      state_d = state_q;
      if (!cfg_enable) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE:    state_d = S_ARMED;
            S_ARMED:   if (fire) state_d = S_TRIG; else if (lead)  state_d = S_MEASURE;
            S_MEASURE: if (fire) state_d = S_TRIG; else if (trail) state_d = S_ARMED;
            S_TRIG:    state_d = S_TRIG;
            default:   state_d = S_IDLE;
         endcase
      end
   end

   always_comb begin : fsm_out
      armed         = (state_q == S_ARMED) || (state_q == S_MEASURE);
      triggered     = triggered_q;
      trigger_pulse = trigger_pulse_q;
      event_count   = event_count_q;
   end

   always_ff @(posedge clk) begin
      if (rst_sync) begin
         state_q         <= S_IDLE;
         sync_q          <= '0;
         sig_dly_q       <= 1'b0;
         pos_q           <= 1'b0;
         type_q          <= 3'd0;
         stage_q         <= 4'd0;
         tb_q            <= 3'd0;
         c1_q            <= 8'd0;
         c2_q            <= 8'd0;
         lne_q           <= 1'b0;
         presc_q         <= 14'd0;
         width_q         <= 8'd0;
         idle_q          <= 8'd0;
         evt_q           <= 1'b0;
         event_count_q   <= 4'd0;
         triggered_q     <= 1'b0;
         trigger_pulse_q <= 1'b0;
      end else begin
         state_q         <= state_d;
         sync_q          <= sync_d;
         sig_dly_q       <= sig_dly_d;
         pos_q           <= pos_d;
         type_q          <= type_d;
         stage_q         <= stage_d;
         tb_q            <= tb_d;
         c1_q            <= c1_d;
         c2_q            <= c2_d;
         lne_q           <= lne_d;
         presc_q         <= presc_d;
         width_q         <= width_d;
         idle_q          <= idle_d;
         evt_q           <= evt_d;
         event_count_q   <= event_count_d;
         triggered_q     <= triggered_d;
         trigger_pulse_q <= trigger_pulse_d;
      end
   end

endmodule

// File: tb/tb_scarf_trigger_engine.sv
// -----------------------------------------------------------------------------
// tb_scarf_trigger_engine
//
// Directed bench for scarf_trigger_engine. Inputs change on the falling clock
// edge, outputs are sampled on the falling edge. Expected values are worked
// out by hand from the stimulus (pulse lengths, tick periods, latencies).
// -----------------------------------------------------------------------------
module tb_scarf_trigger_engine;

   logic       clk = 1'b0;
   logic       rst_sync;
   logic       sig_in;
   logic       cfg_enable;
   logic       cfg_positive;
   logic [2:0] cfg_type;
   logic [3:0] cfg_stage1_count;
   logic [2:0] cfg_time_base;
   logic [7:0] cfg_count1;
   logic [7:0] cfg_count2;
   logic       cfg_longer_no_edge;
   logic       armed;
   logic       triggered;
   logic       trigger_pulse;
   logic [3:0] event_count;

   int n_checks  = 0;
   int n_fail    = 0;
   int pulse_cnt = 0;
   int p0;

   always #5 clk = ~clk;

   scarf_trigger_engine #(.SYNC_STAGES(2)) dut (
      .clk                (clk),
      .rst_sync           (rst_sync),
      .sig_in             (sig_in),
      .cfg_enable         (cfg_enable),
      .cfg_positive       (cfg_positive),
      .cfg_type           (cfg_type),
      .cfg_stage1_count   (cfg_stage1_count),
      .cfg_time_base      (cfg_time_base),
      .cfg_count1         (cfg_count1),
      .cfg_count2         (cfg_count2),
      .cfg_longer_no_edge (cfg_longer_no_edge),
      .armed              (armed),
      .triggered          (triggered),
      .trigger_pulse      (trigger_pulse),
      .event_count        (event_count)
   );

   // Total number of trigger strobes seen, used to prove "no extra pulse".
   always @(posedge clk) if (trigger_pulse) pulse_cnt <= pulse_cnt + 1;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end else begin
         $display("ok   %s: %0d", tag, got);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse_hi(input int len);
      sig_in = 1'b1;
      step(len);
      sig_in = 1'b0;
   endtask

   task automatic arm();
      cfg_enable = 1'b1;
      step(1);
   endtask

   task automatic disarm();
      cfg_enable = 1'b0;
      step(1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_sync = 1'b1; sig_in = 1'b0; cfg_enable = 1'b0; cfg_positive = 1'b1;
      cfg_type = 3'd0; cfg_stage1_count = 4'd1; cfg_time_base = 3'd0;
      cfg_count1 = 8'd0; cfg_count2 = 8'd0; cfg_longer_no_edge = 1'b0;

      // ---- reset ----
      step(3);
      check_eq("rst_armed", 32'(armed), 0);
      check_eq("rst_triggered", 32'(triggered), 0);
      check_eq("rst_pulse", 32'(trigger_pulse), 0);
      check_eq("rst_count", 32'(event_count), 0);
      rst_sync = 1'b0;
      step(2);

      // ---- EDGE, rising, stage1=1: pulse 3 clocks after first sampling edge ----
      arm();
      check_eq("edge_armed", 32'(armed), 1);
      step(2);
      p0 = pulse_cnt;
      sig_in = 1'b1;
      step(3);
      check_eq("edge_lat_early", 32'(trigger_pulse), 0);
      step(1);
      check_eq("edge_lat", 32'(trigger_pulse), 1);
      check_eq("edge_triggered", 32'(triggered), 1);
      check_eq("edge_count", 32'(event_count), 1);
      step(1);
      check_eq("edge_one_clk", 32'(trigger_pulse), 0);
      check_eq("edge_sticky", 32'(triggered), 1);
      sig_in = 1'b0; step(4); sig_in = 1'b1; step(8);
      check_eq("edge_no_retrig", pulse_cnt - p0, 1);
      check_eq("edge_hold_unarmed", 32'(armed), 0);
      disarm();
      check_eq("edge_dis_trig", 32'(triggered), 0);
      check_eq("edge_dis_count", 32'(event_count), 0);
      sig_in = 1'b0; step(4);

      // ---- WIDTH_GT, count1=10 ----
      cfg_type = 3'd1; cfg_count1 = 8'd10;
      arm(); step(2);
      p0 = pulse_cnt;
      pulse_hi(10); step(8);
      check_eq("gt_10_count", 32'(event_count), 0);
      check_eq("gt_10_pulses", pulse_cnt - p0, 0);
      pulse_hi(11); step(3);
      check_eq("gt_11_early", 32'(trigger_pulse), 0);
      step(1);
      check_eq("gt_11_trail", 32'(trigger_pulse), 1);
      disarm(); step(2);

      // ---- WIDTH_GT with longer_no_edge: fires on clock 11 of a 50-clock pulse ----
      cfg_longer_no_edge = 1'b1;
      arm(); step(2);
      sig_in = 1'b1;
      step(13);
      check_eq("gtne_early", 32'(trigger_pulse), 0);
      step(1);
      check_eq("gtne_fire", 32'(trigger_pulse), 1);
      check_eq("gtne_count", 32'(event_count), 1);
      step(36); sig_in = 1'b0; step(6);
      check_eq("gtne_sticky", 32'(triggered), 1);
      disarm(); cfg_longer_no_edge = 1'b0; step(2);

      // ---- WIDTH_LT, count1=5, stage1=2 ----
      cfg_type = 3'd2; cfg_count1 = 8'd5; cfg_stage1_count = 4'd2;
      arm(); step(2);
      pulse_hi(4); step(8);
      check_eq("lt_4", 32'(event_count), 1);
      pulse_hi(5); step(8);
      check_eq("lt_5", 32'(event_count), 1);
      pulse_hi(3); step(8);
      check_eq("lt_3_trig", 32'(triggered), 1);
      check_eq("lt_3_count", 32'(event_count), 2);
      disarm(); step(2);

      // ---- WIDTH_IN, tb=1, count1=3, count2=5: widths 2, 4, 6 ticks ----
      cfg_type = 3'd3; cfg_time_base = 3'd1; cfg_count1 = 8'd3; cfg_count2 = 8'd5;
      cfg_stage1_count = 4'd4;
      arm(); step(2);
      pulse_hi(8); step(10);
      check_eq("in_8", 32'(event_count), 0);
      pulse_hi(16); step(10);
      check_eq("in_16", 32'(event_count), 1);
      pulse_hi(24); step(10);
      check_eq("in_24", 32'(event_count), 1);
      check_eq("in_not_trig", 32'(triggered), 0);
      disarm();
      cfg_count1 = 8'd6; cfg_count2 = 8'd2; cfg_stage1_count = 4'd1;
      arm(); step(2);
      for (int i = 1; i <= 5; i++) begin
         pulse_hi(8 * i); step(10);
      end
      check_eq("in_empty_count", 32'(event_count), 0);
      check_eq("in_empty_trig", 32'(triggered), 0);
      disarm(); step(2);

      // ---- stage count, EDGE falling, stage1=3 then stage1=0 ----
      cfg_type = 3'd0; cfg_time_base = 3'd0; cfg_positive = 1'b0; cfg_stage1_count = 4'd3;
      sig_in = 1'b1; step(4);
      arm(); step(2);
      sig_in = 1'b0; step(5);
      check_eq("stg_1", 32'(event_count), 1);
      sig_in = 1'b1; step(5);
      sig_in = 1'b0; step(5);
      check_eq("stg_2", 32'(event_count), 2);
      check_eq("stg_2_trig", 32'(triggered), 0);
      sig_in = 1'b1; step(5);
      sig_in = 1'b0; step(3);
      check_eq("stg_3_early", 32'(trigger_pulse), 0);
      step(1);
      check_eq("stg_3_fire", 32'(trigger_pulse), 1);
      check_eq("stg_3_count", 32'(event_count), 3);
      disarm();
      sig_in = 1'b1; cfg_stage1_count = 4'd0; step(4);
      arm(); step(2);
      sig_in = 1'b0; step(4);
      check_eq("stg_0_fire", 32'(trigger_pulse), 1);
      check_eq("stg_0_count", 32'(event_count), 1);
      disarm(); cfg_positive = 1'b1; sig_in = 1'b0; step(4);

      // ---- IDLE, count1=20: toggles every 15 clocks, then a quiet gap ----
      cfg_type = 3'd4; cfg_count1 = 8'd20; cfg_stage1_count = 4'd1;
      arm();
      for (int i = 0; i < 6; i++) begin
         sig_in = ~sig_in; step(15);
      end
      check_eq("idle_busy_trig", 32'(triggered), 0);
      check_eq("idle_busy_count", 32'(event_count), 0);
      step(9);
      check_eq("idle_gap_early", 32'(trigger_pulse), 0);
      step(1);
      check_eq("idle_gap_fire", 32'(trigger_pulse), 1);
      disarm(); sig_in = 1'b0; step(4);

      // ---- control: disarm mid-measure, live cfg change, reset ----
      cfg_type = 3'd1; cfg_count1 = 8'd10;
      arm(); step(2);
      p0 = pulse_cnt;
      sig_in = 1'b1; step(6);
      check_eq("ctl_measure_armed", 32'(armed), 1);
      cfg_enable = 1'b0; step(1);
      check_eq("ctl_disarm_armed", 32'(armed), 0);
      check_eq("ctl_disarm_count", 32'(event_count), 0);
      sig_in = 1'b0; step(20);
      check_eq("ctl_disarm_pulses", pulse_cnt - p0, 0);
      check_eq("ctl_disarm_trig", 32'(triggered), 0);
      arm(); step(2);
      cfg_count1 = 8'd2;
      pulse_hi(5); step(8);
      check_eq("ctl_cfg_ignored", 32'(triggered), 0);
      pulse_hi(12); step(8);
      check_eq("ctl_snap_live", 32'(triggered), 1);
      rst_sync = 1'b1; step(1);
      check_eq("ctl_rst_trig", 32'(triggered), 0);
      check_eq("ctl_rst_pulse", 32'(trigger_pulse), 0);
      check_eq("ctl_rst_armed", 32'(armed), 0);
      check_eq("ctl_rst_count", 32'(event_count), 0);
      rst_sync = 1'b0; cfg_enable = 1'b0; step(2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
